// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (Booth radix-2) / DIV (restoring) engine feeding HI/LO.
// Optional macro DIVZERO_EXC_EN: adds div_zero output and a fast divide-by-zero exit.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out
`ifdef DIVZERO_EXC_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FINISH} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc;    // MULT: Booth accumulator; DIV: partial remainder
  logic [WIDTH:0]   mcand;  // MULT: sign-extended multiplicand; DIV: |divisor|
  logic [WIDTH-1:0] qr;     // MULT: multiplier/product low; DIV: dividend/quotient
  logic             q1;
  logic             op_r;
  logic             neg_q;
  logic             neg_r;
`ifdef DIVZERO_EXC_EN
  logic             dz;
`endif

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             last;

  always_comb begin
    booth_sum = acc;
    case ({qr[0], q1})
      2'b01:   booth_sum = acc + mcand;
      2'b10:   booth_sum = acc - mcand;
      default: booth_sum = acc;
    endcase
  end

  assign div_shift = {acc[WIDTH-1:0], qr[WIDTH-1]};
  assign div_diff  = div_shift - mcand;
  assign div_ge    = (div_shift >= mcand);
  assign a_mag     = a[WIDTH-1] ? -a : a;
  assign b_mag     = b[WIDTH-1] ? -b : b;
  assign last      = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      qr     <= '0;
      q1     <= 1'b0;
      op_r   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      HI_out <= '0;
      LO_out <= '0;
`ifdef DIVZERO_EXC_EN
      dz       <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef DIVZERO_EXC_EN
      div_zero <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            acc  <= '0;
            q1   <= 1'b0;
            op_r <= op;
`ifdef DIVZERO_EXC_EN
            dz   <= 1'b0;
`endif
            if (op) begin
              qr    <= a_mag;
              mcand <= {1'b0, b_mag};
              // A zero divisor leaves the quotient as all ones, so no negation.
              neg_q <= (a[WIDTH-1] ^ b[WIDTH-1]) & (|b);
              neg_r <= a[WIDTH-1];
`ifdef DIVZERO_EXC_EN
              if (b == '0) begin
                state <= S_FINISH;
                dz    <= 1'b1;
              end else
`endif
              state <= S_DIV;
            end else begin
              qr    <= b;
              mcand <= {a[WIDTH-1], a};
              state <= S_MULT;
            end
          end
        end
        S_MULT: begin
          acc <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          qr  <= {booth_sum[0], qr[WIDTH-1:1]};
          q1  <= qr[0];
          cnt <= cnt + 1'b1;
          if (last) state <= S_FINISH;
        end
        S_DIV: begin
          acc <= div_ge ? div_diff : div_shift;
          qr  <= {qr[WIDTH-2:0], div_ge};
          cnt <= cnt + 1'b1;
          if (last) state <= S_FINISH;
        end
        S_FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
`ifdef DIVZERO_EXC_EN
          div_zero <= dz;
          if (!dz) begin
`else
          begin
`endif
            if (op_r) begin
              HI_out <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
              LO_out <= neg_q ? -qr : qr;
            end else begin
              HI_out <= acc[WIDTH-1:0];
              LO_out <= qr;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
